irq_pending_ctrl8: RTL
======================

Name: irq_pending_ctrl8

Overview:
- Sequential interrupt front end that sits directly upstream of the 8-to-3 priority encoder.
- Synchronises 8 asynchronous request lines, captures rising edges into a pending register and applies a mask.
- Feeds the masked pending vector to the encoder and presents the winning index to a consumer over a valid/ack handshake.
- Clears the serviced pending bit when the consumer acknowledges.

Parameters:
- SYNC_STAGES, 2, synchroniser depth per request line (legal values 2..4).
- LEVEL_MODE, 0, 0 = rising-edge capture into pending; 1 = pending follows the synchronised level (no latching).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_in  in  8  raw asynchronous request lines; bit 7 is highest priority.
- irq_mask  in  8  1 = source disabled; synchronous to clk.
- irq_valid  out  1  an interrupt is being presented.
- irq_id  out  3  index of the presented source; valid only while irq_valid = 1.
- irq_ack  in  1  consumer accepts irq_id; sampled only while irq_valid = 1.
- pending  out  8  raw pending register, for debug/status.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, on rst_n.
- Reset: all synchroniser flops, edge-history flops and pending are 0; irq_valid = 0; irq_id = 3'b000; FSM enters IDLE. Reset mid-handshake drops irq_valid immediately (asynchronously) and discards all pending.
- Synchroniser: SYNC_STAGES flops per bit; sync[i] is the last stage.
- Edge capture (LEVEL_MODE = 0): rise[i] = sync[i] & ~prev[i], where prev is sync delayed one cycle. pending[i] sets on rise[i] and clears on an ack of source i. If set and clear coincide on the same bit, set wins, so a new edge is never lost. Pending bits are captured regardless of mask; masking affects arbitration only.
- Level mode (LEVEL_MODE = 1): pending = sync. Ack does not clear it; the source must deassert.
- Arbitration: req = pending & ~irq_mask drives the encoder combinationally, giving an index enc_y and any-request flag enc_z. Bit 7 wins; bit 0 is lowest.
- FSM states:
  - IDLE: irq_valid = 0. If enc_z = 1, latch irq_id <= enc_y and go to PRESENT.
  - PRESENT: irq_valid = 1; irq_id is held stable. There is no preemption, even if a higher-priority request arrives or irq_mask changes. On irq_ack = 1, clear pending[irq_id] (edge mode) and go to GAP.
  - GAP: irq_valid = 0 for exactly one cycle so the cleared pending bit settles; then go to IDLE.
- Latency: an irq_in edge reaches pending after SYNC_STAGES+1 clk edges. irq_valid rises 1 cycle after req becomes nonzero in IDLE. Ack-to-next-valid is a minimum of 2 cycles (GAP, then IDLE re-arbitration).
- irq_ack while irq_valid = 0 is ignored.
- All sources masked while pending: nothing is presented and pending is retained. Unmasking presents the highest-priority source 1 cycle later.
- A held source in edge mode produces exactly one pending event per rising edge.

Decomposition:
- Shared package:
  - NUM_IRQ = 8 and IRQ_ID_W = 3.
  - FSM state enum {IDLE, PRESENT, GAP}, 2-bit encoding.
- Sub-module: instantiate the existing priority_encoder8to3 for arbitration (x = req, y → enc_y, z → enc_z). Do not duplicate the priority logic.
- The synchroniser is inline (generate loop). It does not warrant its own module.

Test Plan:
1. Reset, then pulse irq_in[5] for 1 cycle → pending = 8'h20 after 3 clk edges (SYNC_STAGES = 2); irq_valid = 1, irq_id = 3'd5 the next cycle. Assert irq_ack → pending = 8'h00, irq_valid = 0, and it stays 0.
2. Edges on bits 1, 4 and 7 in the same cycle → presented in order 7, 4, 1 with acks. Between acks irq_valid is low for ≥ 2 cycles; final pending = 8'h00.
3. While presenting id 2, raise irq_in[6] → irq_id stays 2 until ack; after GAP, irq_id = 6.
4. irq_mask = 8'hFF, edge on bit 3 → pending = 8'h08 and irq_valid stays 0. Clear the mask → irq_valid = 1, irq_id = 3 one cycle later.
5. Same-cycle ack of id 0 and a new rising edge on bit 0 → pending[0] remains 1 and id 0 is re-presented after GAP.
6. Assert rst_n = 0 mid-PRESENT with pending = 8'h90 → irq_valid = 0 and pending = 8'h00 asynchronously. After release with no edges, irq_valid stays 0.

Source files
------------

// File: rtl/irq_pending_ctrl8_pkg.sv
// Shared constants and FSM state type for the interrupt pending controller.
package irq_pending_ctrl8_pkg;

  localparam int NUM_IRQ  = 8;
  localparam int IRQ_ID_W = 3;

  // IDLE: arbitrate, PRESENT: offer irq_id, GAP: one quiet cycle after ack.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } irq_state_e;

endpackage

// File: rtl/priority_encoder8to3.sv
// 8-to-3 priority encoder: y is the index of the highest set bit of x,
// z flags that any bit is set. y is 0 when x is all zero.
module priority_encoder8to3 (
  input  logic [7:0] x,
  output logic [2:0] y,
  output logic       z
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    y = 3'd0;
    z = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) begin
        y = i[2:0];
        z = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl8.sv
// Interrupt front end: synchronises 8 request lines, captures rising edges
// into a pending register, masks, arbitrates through the priority encoder
// and offers the winner over a valid/ack handshake.
//
// Handshake: irq_valid is high only in PRESENT and irq_id is stable for the
// whole time it is high. The consumer accepts by raising irq_ack while
// irq_valid is high; the transfer completes on that clock edge. irq_ack seen
// while irq_valid is low has no effect. After an accept irq_valid stays low
// for at least two cycles (GAP, then IDLE re-arbitration).
module irq_pending_ctrl8
  import irq_pending_ctrl8_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit LEVEL_MODE  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  output logic                irq_valid,
  output logic [IRQ_ID_W-1:0] irq_id,
  input  logic                irq_ack,
  output logic [NUM_IRQ-1:0]  pending
);

  logic [NUM_IRQ-1:0]  sync_level;
  logic [NUM_IRQ-1:0]  prev_q, prev_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  clr_vec;
  logic [NUM_IRQ-1:0]  req;
  logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;
  logic [IRQ_ID_W-1:0] enc_y;
  logic                enc_z;
  logic                ack_fire;
  irq_state_e          state_q, state_d;

  // Per-line synchroniser chain; the last stage is the usable level.
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    // Shift the raw line into the bottom of the chain.
    always_comb begin
      chain_d = {chain_q[SYNC_STAGES-2:0], irq_in[i]};
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain_q <= '0;
      else        chain_q <= chain_d;
    end

    assign sync_level[i] = chain_q[SYNC_STAGES-1];
  end

  // Edge detect, ack clear and pending update; a new edge beats a same-cycle clear.
  always_comb begin
    prev_d   = sync_level;
    rise     = sync_level & ~prev_q;
    ack_fire = (state_q == PRESENT) && irq_ack;
    clr_vec  = '0;
    if (ack_fire) clr_vec[irq_id_q] = 1'b1;
    if (LEVEL_MODE) pending_d = sync_level;
    else            pending_d = (pending_q & ~clr_vec) | rise;
    req = pending_q & ~irq_mask;
  end

  priority_encoder8to3 u_enc (
    .x (req),
    .y (enc_y),
    .z (enc_z)
  );

  // Latch the winning index only when leaving IDLE; held through PRESENT.
  always_comb begin
    irq_id_d = irq_id_q;
    if ((state_q == IDLE) && enc_z) irq_id_d = enc_y;
  end

  // Edge history, pending and presented id registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      irq_id_q  <= '0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      irq_id_q  <= irq_id_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: no preemption while PRESENT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enc_z)   state_d = PRESENT;
      PRESENT: if (irq_ack) state_d = GAP;
      GAP:                  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    irq_valid = (state_q == PRESENT);
    irq_id    = irq_id_q;
    pending   = pending_q;
  end

endmodule
